// File: rtl/get_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : get_reg_pkg                                                |
// | Description : Shared types, index ranges and ASCII constants for the     |
// |               register-index to ABI-name lookup.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package get_reg_pkg;

    typedef logic [31:0] name_t;
    typedef logic [2:0]  len_t;

    localparam logic [5:0] XREG_BASE = 6'd0;
    localparam logic [5:0] FREG_BASE = 6'd32;

    localparam logic [7:0] C_CHR_0 = 8'h30;
    localparam logic [7:0] C_CHR_1 = 8'h31;
    localparam logic [7:0] C_CHR_A = 8'h61;
    localparam logic [7:0] C_CHR_E = 8'h65;
    localparam logic [7:0] C_CHR_F = 8'h66;
    localparam logic [7:0] C_CHR_G = 8'h67;
    localparam logic [7:0] C_CHR_O = 8'h6F;
    localparam logic [7:0] C_CHR_P = 8'h70;
    localparam logic [7:0] C_CHR_R = 8'h72;
    localparam logic [7:0] C_CHR_S = 8'h73;
    localparam logic [7:0] C_CHR_T = 8'h74;
    localparam logic [7:0] C_CHR_Z = 8'h7A;

    // Decimal ASCII digit for 0..9
    function automatic logic [7:0] ascii_digit(input logic [3:0] num);
        return C_CHR_0 + {4'b0000, num};
    endfunction

    // Right-justified prefix (1-2 chars in a 16-bit field) followed by a 1-2 digit suffix
    function automatic name_t num_name(input logic [15:0] pfx, input logic [3:0] num);
        name_t w_name;
        if (num >= 4'd10) begin
            w_name = {pfx, C_CHR_1, ascii_digit(num - 4'd10)};
        end else begin
            w_name = {8'h00, pfx, ascii_digit(num)};
        end
        return w_name;
    endfunction

    // Character count matching num_name
    function automatic len_t num_len(input len_t pfx_len, input logic [3:0] num);
        return (num >= 4'd10) ? len_t'(pfx_len + 3'd2) : len_t'(pfx_len + 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/get_reg_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : get_reg_rom                                                |
// | Description : Combinational register index -> ABI name/length/error.     |
// |               FP names (indices 32-63) only when GET_REG_FPR_EN defined. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module get_reg_rom
    import get_reg_pkg::*;
(
    input  logic [5:0]  idx,
    output name_t       name,
    output len_t        len,
    output logic        err
);

    logic [4:0]  w_reg;
    logic        w_fixed;
    name_t       w_fixed_name;
    len_t        w_fixed_len;
    logic [15:0] w_pfx;
    len_t        w_plen;
    logic [3:0]  w_num;
    logic        w_err;

    assign w_reg = idx[4:0];

    // Classify the index into a fixed name or a prefix plus numeric suffix
    always_comb begin
        w_fixed      = 1'b0;
        w_fixed_name = '0;
        w_fixed_len  = '0;
        w_pfx        = '0;
        w_plen       = '0;
        w_num        = '0;
        w_err        = 1'b0;
        if (idx < FREG_BASE) begin
            if (w_reg == 5'd0) begin
                w_fixed      = 1'b1;
                w_fixed_name = {C_CHR_Z, C_CHR_E, C_CHR_R, C_CHR_O};
                w_fixed_len  = 3'd4;
            end else if (w_reg <= 5'd4) begin
                w_fixed     = 1'b1;
                w_fixed_len = 3'd2;
                case (w_reg)
                    5'd1:    w_fixed_name = {16'h0000, C_CHR_R, C_CHR_A};
                    5'd2:    w_fixed_name = {16'h0000, C_CHR_S, C_CHR_P};
                    5'd3:    w_fixed_name = {16'h0000, C_CHR_G, C_CHR_P};
                    default: w_fixed_name = {16'h0000, C_CHR_T, C_CHR_P};
                endcase
            end else if (w_reg <= 5'd7) begin
                w_pfx  = {8'h00, C_CHR_T};
                w_plen = 3'd1;
                w_num  = 4'(w_reg - 5'd5);
            end else if (w_reg <= 5'd9) begin
                w_pfx  = {8'h00, C_CHR_S};
                w_plen = 3'd1;
                w_num  = 4'(w_reg - 5'd8);
            end else if (w_reg <= 5'd17) begin
                w_pfx  = {8'h00, C_CHR_A};
                w_plen = 3'd1;
                w_num  = 4'(w_reg - 5'd10);
            end else if (w_reg <= 5'd27) begin
                w_pfx  = {8'h00, C_CHR_S};
                w_plen = 3'd1;
                w_num  = 4'(w_reg - 5'd16);
            end else begin
                w_pfx  = {8'h00, C_CHR_T};
                w_plen = 3'd1;
                w_num  = 4'(w_reg - 5'd25);
            end
        end else begin
`ifdef GET_REG_FPR_EN
            w_plen = 3'd2;
            if (w_reg <= 5'd7) begin
                w_pfx = {C_CHR_F, C_CHR_T};
                w_num = 4'(w_reg);
            end else if (w_reg <= 5'd9) begin
                w_pfx = {C_CHR_F, C_CHR_S};
                w_num = 4'(w_reg - 5'd8);
            end else if (w_reg <= 5'd17) begin
                w_pfx = {C_CHR_F, C_CHR_A};
                w_num = 4'(w_reg - 5'd10);
            end else if (w_reg <= 5'd27) begin
                w_pfx = {C_CHR_F, C_CHR_S};
                w_num = 4'(w_reg - 5'd16);
            end else begin
                w_pfx = {C_CHR_F, C_CHR_T};
                w_num = 4'(w_reg - 5'd20);
            end
`else
            w_err = 1'b1;
`endif
        end
    end

    // Assemble the final name/length; unsupported indices return all zeros
    always_comb begin
        name = '0;
        len  = '0;
        err  = w_err;
        if (!w_err) begin
            if (w_fixed) begin
                name = w_fixed_name;
                len  = w_fixed_len;
            end else begin
                name = num_name(w_pfx, w_num);
                len  = num_len(w_plen, w_num);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/get_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : get_reg                                                    |
// | Description : Registered RISC-V register index -> ABI name lookup,       |
// |               1-cycle latency, fully pipelined. FP names are enabled     |
// |               by defining GET_REG_FPR_EN.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module get_reg
    import get_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_idx,
    output logic        rsp_valid,
    output logic [31:0] rsp_name,
    output logic [2:0]  rsp_len,
    output logic        rsp_err
);

    name_t w_name;
    len_t  w_len;
    logic  w_err;

    logic  r_valid;
    name_t r_name;
    len_t  r_len;
    logic  r_err;

    get_reg_rom u_rom (
        .idx  (req_idx),
        .name (w_name),
        .len  (w_len),
        .err  (w_err)
    );

    // Capture the lookup on each request; payload holds while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_name  <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= req_valid;
            if (req_valid) begin
                r_name <= w_name;
                r_len  <= w_len;
                r_err  <= w_err;
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_name  = r_name;
    assign rsp_len   = r_len;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_get_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_get_reg                                                 |
// | Description : Scoreboard testbench for get_reg (both FP build options).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_get_reg;

    typedef struct {
        logic [31:0] name;
        logic [2:0]  len;
        logic        err;
        logic [5:0]  idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [5:0]  req_idx;
    logic        rsp_valid;
    logic [31:0] rsp_name;
    logic [2:0]  rsp_len;
    logic        rsp_err;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    exp_t last_exp;

    string xnames[32] = '{"zero","ra","sp","gp","tp","t0","t1","t2",
                          "s0","s1","a0","a1","a2","a3","a4","a5",
                          "a6","a7","s2","s3","s4","s5","s6","s7",
                          "s8","s9","s10","s11","t3","t4","t5","t6"};
    string fnames[32] = '{"ft0","ft1","ft2","ft3","ft4","ft5","ft6","ft7",
                          "fs0","fs1","fa0","fa1","fa2","fa3","fa4","fa5",
                          "fa6","fa7","fs2","fs3","fs4","fs5","fs6","fs7",
                          "fs8","fs9","fs10","fs11","ft8","ft9","ft10","ft11"};

    get_reg dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .rsp_valid (rsp_valid),
        .rsp_name  (rsp_name),
        .rsp_len   (rsp_len),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] idx);
        exp_t  e;
        string s;
        e.idx  = idx;
        e.err  = 1'b0;
        e.name = '0;
        if (idx < 6'd32) begin
            s = xnames[idx[4:0]];
        end else begin
`ifdef GET_REG_FPR_EN
            s = fnames[idx[4:0]];
`else
            s = "";
            e.err = 1'b1;
`endif
        end
        for (int i = 0; i < s.len(); i++) e.name = {e.name[23:0], s[i]};
        e.len = 3'(s.len());
        return e;
    endfunction

    // One clock: drive request, then compare just after the capturing edge
    task automatic step(input logic v, input logic [5:0] idx);
        exp_t e;
        req_valid = v;
        req_idx   = idx;
        if (v) sb_q.push_back(model(idx));
        @(posedge clk);
        #1;
        if (v) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("valid[%0d]", e.idx), {31'd0, rsp_valid}, 32'd1);
                check($sformatf("name[%0d]", e.idx), rsp_name, e.name);
                check($sformatf("len[%0d]", e.idx), {29'd0, rsp_len}, {29'd0, e.len});
                check($sformatf("err[%0d]", e.idx), {31'd0, rsp_err}, {31'd0, e.err});
                last_exp = e;
            end
        end else begin
            check("idle_valid", {31'd0, rsp_valid}, 32'd0);
            check("idle_hold_name", rsp_name, last_exp.name);
            check("idle_hold_len", {29'd0, rsp_len}, {29'd0, last_exp.len});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_name"}, rsp_name, 32'd0);
        check({tag, "_len"}, {29'd0, rsp_len}, 32'd0);
        check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_idx   = '0;
        last_exp  = '{name: 32'd0, len: 3'd0, err: 1'b0, idx: 6'd0};
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Spot checks with literal expectations
        step(1'b1, 6'd0);  check("lit_zero", rsp_name, 32'h7A65726F);
        step(1'b1, 6'd2);  check("lit_sp", rsp_name, 32'h00007370);
        step(1'b1, 6'd27); check("lit_s11", rsp_name, 32'h00733131);
        step(1'b1, 6'd31); check("lit_t6", rsp_name, 32'h00007436);

        // Back-to-back a0, a1, a2
        step(1'b1, 6'd10);
        step(1'b1, 6'd11);
        step(1'b1, 6'd12);

        // Idle hold after ra
        step(1'b1, 6'd1);
        step(1'b0, 6'd5);
        check("lit_ra_hold", rsp_name, 32'h00007261);

        // FP region
        step(1'b1, 6'd32);
        step(1'b1, 6'd50);
        step(1'b1, 6'd40);
`ifdef GET_REG_FPR_EN
        step(1'b1, 6'd32); check("lit_ft0", rsp_name, 32'h00667430);
        step(1'b1, 6'd50); check("lit_fs10", rsp_name, 32'h66733130);
`else
        step(1'b1, 6'd40); check("lit_f40_err", {31'd0, rsp_err}, 32'd1);
`endif

        // Full sweep with random idle gaps
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 6'(i));
            if ($urandom_range(0, 3) == 0) step(1'b0, 6'($urandom_range(0, 63)));
        end

        // Asynchronous reset mid-request: outputs clear without a clock edge
        step(1'b1, 6'd1);
        req_valid = 1'b1;
        req_idx   = 6'd3;
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        req_valid = 1'b0;
        rst = 1'b0;
        last_exp = '{name: 32'd0, len: 3'd0, err: 1'b0, idx: 6'd0};
        step(1'b0, 6'd0);
        step(1'b1, 6'd8);
        check("post_rst_s0", rsp_name, 32'h00007330);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
